uart_apb_sched: RTL and testbench
=================================

Name: uart_apb_sched

Overview:
- APB master sequencer that shares the UART's single APB slave port between two requesters.
  - Requester 0: host register-access bridge.
  - Requester 1: UART DMA channel, paced by TXDRDYn/RXDRDYn.
- Round-robin arbitration; generates the APB SETUP/ACCESS phases, honours PREADY wait states, and returns read data and error status to the granted requester.
- Sits between the requesters and the UART top's PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR pins.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT_CYCLES, 16, ACCESS cycles with PREADY low before abort; only used with UART_APB_TIMEOUT_EN. Legal range 1..255.

Ports:
- PCLK  input  1  single clock; all logic on rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- req_valid  input  2  request pending, one bit per requester i.
- req_write  input  2  1 = write, 0 = read, per requester.
- req_addr  input  2*ADDR_W  requester i address at [ADDR_W*i +: ADDR_W].
- req_wdata  input  2*DATA_W  requester i write data, same packing.
- req_ready  output  2  one-hot accept pulse; command captured this cycle.
- rsp_valid  output  2  one-hot completion pulse, one cycle.
- rsp_rdata  output  DATA_W  read data, valid with rsp_valid.
- rsp_err  output  1  error flag, valid with rsp_valid.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB access phase.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_W  APB address.
- PWDATA  output  DATA_W  APB write data.
- PRDATA  input  DATA_W  APB read data.
- PREADY  input  1  APB ready / wait state.
- PSLVERR  input  1  APB slave error.

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer):
  - All outputs are 0; state is IDLE; round-robin pointer is 0, so requester 0 wins the first tie.
  - An in-flight transfer is dropped with no rsp_valid.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid bit is set, the arbiter grants one requester.
  - req_ready[g] is asserted combinationally in the same cycle.
  - write, addr and wdata are latched; next state is SETUP.
  - With no request, remain in IDLE.
- Arbitration:
  - Two-way round robin; a single requester is always granted.
  - On a tie, the requester indicated by the pointer wins.
  - The pointer moves to the non-granted requester at grant time.
- SETUP: PSEL=1, PENABLE=0; PWRITE/PADDR/PWDATA driven from the latch (PWDATA=0 on reads); next state is ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; all address, control and data held stable.
  - PREADY=0: stay in ACCESS.
  - PREADY=1: next cycle rsp_valid[g]=1, rsp_rdata=PRDATA (0 for writes), rsp_err=PSLVERR; PSEL/PENABLE drop to 0; state returns to IDLE.
- Latency:
  - Accept at T, SETUP at T+1, ACCESS at T+2.
  - With zero wait states, rsp_valid at T+3. A new accept is possible at T+3.
  - Minimum period is 3 cycles per transfer.
- Outside IDLE: req_ready=0. Requesters must hold req_valid and their fields until req_ready.
- rsp_rdata and rsp_err are 0 when rsp_valid=0.
- A requester deasserting req_valid before grant is legal; no transfer is issued for it.
- PSLVERR is sampled only when PREADY=1 in ACCESS.

Optional Feature:
- Macro: UART_APB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: PSEL/PENABLE go to 0 next cycle, rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, state returns to IDLE.
  - PREADY=1 in the same cycle as the threshold wins; it is a normal completion.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Decomposition:
- Package uart_apb_pkg:
  - apb_state_e enum {IDLE, SETUP, ACCESS}.
  - apb_cmd_t struct {write, addr, wdata}.
  - Constants NUM_REQ=2 and TIMEOUT_W=8.
- Sub-module uart_rr_arb2:
  - 2-way round-robin grant with a registered pointer.
  - Inputs: req[1:0], advance. Output: one-hot gnt[1:0].

Test Plan:
- Single write, req 0 (addr 0x03, wdata 0xA5), PREADY=1:
  - PSEL rises at T+1, PENABLE at T+2, PADDR=0x03, PWDATA=0xA5.
  - rsp_valid=2'b01 at T+3, rsp_err=0.
- Read, req 1 (addr 0x00), PREADY low for 3 ACCESS cycles, PRDATA=0x5C:
  - Signals are stable throughout ACCESS.
  - rsp_valid=2'b10 with rsp_rdata=0x5C one cycle after PREADY is high.
- Both requesters valid continuously for 4 transfers:
  - Grant order 0,1,0,1.
  - req_ready pulses one-hot; no grant outside IDLE.
- Write with PSLVERR=1 and PREADY=1: rsp_err=1, rsp_rdata=0.
- PRESET asserted during ACCESS:
  - PSEL/PENABLE/rsp_valid go to 0 immediately; no response for the dropped transfer.
  - After release, requester 0 wins the first tie.
- With UART_APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY held 0:
  - Abort after 16 ACCESS cycles with rsp_err=1.
  - Without the macro, the bench confirms a 100-cycle wait with no response.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB sequencer.
// UART_APB_TIMEOUT_EN (optional) enables the ACCESS-phase wait-state timeout.
package uart_apb_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned TIMEOUT_W  = 8;
    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the requester that wins a tie.
module uart_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After a grant the pointer favours the requester that lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/uart_apb_sched.sv
// APB master sequencer sharing the UART APB slave between host and DMA requesters.
// Define UART_APB_TIMEOUT_EN to abort transfers stuck in ACCESS for TIMEOUT_CYCLES.
module uart_apb_sched
    import uart_apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_e  state_q, state_d;
    apb_cmd_t    cmd_q, cmd_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [1:0]  arb_gnt;
    logic        arb_adv;
    logic        sel;
`ifdef UART_APB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
`endif

    uart_rr_arb2 u_arb (
        .clk     (PCLK),
        .rst     (PRESET),
        .req     (req_valid),
        .advance (arb_adv),
        .gnt     (arb_gnt)
    );

    assign sel = arb_gnt[1];

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        gnt_d       = gnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        req_ready   = 2'b00;
        arb_adv     = 1'b0;
`ifdef UART_APB_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    arb_adv     = 1'b1;
                    req_ready   = arb_gnt;
                    gnt_d       = arb_gnt;
                    cmd_d.write = req_write[sel];
                    cmd_d.addr  = APB_ADDR_W'(sel ? req_addr[2*ADDR_W-1:ADDR_W]
                                                  : req_addr[ADDR_W-1:0]);
                    cmd_d.wdata = req_write[sel]
                                ? APB_DATA_W'(sel ? req_wdata[2*DATA_W-1:DATA_W]
                                                  : req_wdata[DATA_W-1:0])
                                : '0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef UART_APB_TIMEOUT_EN
                tmo_d     = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d = gnt_q;
                    rsp_rdata_d = cmd_q.write ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    cmd_d       = '0;
                    state_d     = IDLE;
                end
`ifdef UART_APB_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d = gnt_q;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    cmd_d       = '0;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_W'(1);
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                cmd_d     = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            gnt_q       <= 2'b00;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            gnt_q       <= gnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef UART_APB_TIMEOUT_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = cmd_q.write;
    assign PADDR     = ADDR_W'(cmd_q.addr);
    assign PWDATA    = DATA_W'(cmd_q.wdata);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uart_apb_sched.sv
// Scoreboard bench for uart_apb_sched; honours UART_APB_TIMEOUT_EN when defined.
module tb_uart_apb_sched;

    logic        PCLK;
    logic        PRESET;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int checks = 0;
    int failures = 0;

    // slave model controls
    int         wait_n = 0;
    int         acc_cnt = 0;
    logic [7:0] rd_key = 8'h00;
    logic       slv_err = 1'b0;

    logic [1:0]  exp_gnt_q[$];
    logic [10:0] exp_rsp_q[$];

    uart_apb_sched dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // APB slave: PREADY rises on ACCESS cycle number wait_n+1; PRDATA = PADDR ^ rd_key.
    assign PRDATA  = PADDR ^ rd_key;
    assign PSLVERR = slv_err;
    initial PREADY = 1'b0;
    always begin
        @(posedge PCLK);
        #1;
        if (PSEL && PENABLE) begin
            PREADY = (acc_cnt >= wait_n);
            acc_cnt++;
        end else begin
            PREADY = 1'b0;
            acc_cnt = 0;
        end
    end

    // grant monitor
    always @(negedge PCLK) begin
        if (!PRESET && req_ready != 2'b00) begin
            chk("grant_outside_idle", 32'(PSEL), 32'h0);
            if (exp_gnt_q.size() == 0) begin
                chk("unexpected_grant", 32'(req_ready), 32'h0);
            end else begin
                chk("grant", 32'(req_ready), 32'(exp_gnt_q.pop_front()));
            end
        end
    end

    // response monitor
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (rsp_valid != 2'b00) begin
                if (exp_rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'({rsp_valid, rsp_rdata, rsp_err}), 32'h0);
                end else begin
                    chk("rsp", 32'({rsp_valid, rsp_rdata, rsp_err}), 32'(exp_rsp_q.pop_front()));
                end
            end else if (rsp_rdata != 8'h00 || rsp_err != 1'b0) begin
                chk("rsp_idle_zero", 32'({rsp_rdata, rsp_err}), 32'h0);
            end
        end
    end

    task automatic do_xfer(input int r, input logic w, input logic [7:0] a, input logic [7:0] d);
        bit got = 1'b0;
        @(posedge PCLK); #1;
        req_write[r] = w;
        req_addr[8*r +: 8] = a;
        req_wdata[8*r +: 8] = d;
        req_valid[r] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK); #1;
            if (req_ready[r]) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 32'(got), 32'h1);
        @(posedge PCLK); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge PCLK);
            if (exp_gnt_q.size() == 0 && exp_rsp_q.size() == 0) break;
        end
        chk("drain", 32'(exp_gnt_q.size() + exp_rsp_q.size()), 32'h0);
        repeat (2) @(negedge PCLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        int quiet;
        PRESET    = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge PCLK);
        chk("reset_outputs", 32'({req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE,
                                  PWRITE, PADDR, PWDATA}), 32'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // single write, requester 0, zero wait
        wait_n = 0;
        exp_gnt_q.push_back(2'b01);
        exp_rsp_q.push_back({2'b01, 8'h00, 1'b0});
        do_xfer(0, 1'b1, 8'h03, 8'hA5);
        @(negedge PCLK);
        chk("setup_phase", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 32'({3'b101, 8'h03, 8'hA5}));
        @(negedge PCLK);
        chk("access_phase", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 32'({3'b111, 8'h03, 8'hA5}));
        @(negedge PCLK);
        chk("rsp_latency", 32'({rsp_valid, PSEL, PENABLE}), 32'({2'b01, 2'b00}));
        drain();

        // read, requester 1, three wait states
        wait_n = 3;
        rd_key = 8'h5C;
        exp_gnt_q.push_back(2'b10);
        exp_rsp_q.push_back({2'b10, 8'h5C, 1'b0});
        do_xfer(1, 1'b0, 8'h00, 8'hFF);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (PENABLE) begin
                acc++;
                chk("access_stable", 32'({PSEL, PWRITE, PADDR, PWDATA}), 32'({2'b10, 8'h00, 8'h00}));
            end
            if (rsp_valid != 2'b00) break;
        end
        chk("access_cycles", 32'(acc), 32'd4);
        drain();

        // both requesters valid: grant order 0,1,0,1
        wait_n = 0;
        rd_key = 8'h80;
        exp_gnt_q.push_back(2'b01); exp_rsp_q.push_back({2'b01, 8'h90, 1'b0});
        exp_gnt_q.push_back(2'b10); exp_rsp_q.push_back({2'b10, 8'hA1, 1'b0});
        exp_gnt_q.push_back(2'b01); exp_rsp_q.push_back({2'b01, 8'h90, 1'b0});
        exp_gnt_q.push_back(2'b10); exp_rsp_q.push_back({2'b10, 8'hA1, 1'b0});
        @(posedge PCLK); #1;
        req_write = 2'b00;
        req_addr  = {8'h21, 8'h10};
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK); #1;
            if (req_ready != 2'b00) n++;
            if (n == 4) break;
        end
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        chk("tie_grant_count", 32'(n), 32'd4);
        drain();

        // write with slave error
        slv_err = 1'b1;
        exp_gnt_q.push_back(2'b01);
        exp_rsp_q.push_back({2'b01, 8'h00, 1'b1});
        do_xfer(0, 1'b1, 8'h04, 8'h77);
        drain();
        slv_err = 1'b0;

        // reset during ACCESS drops the transfer
        wait_n = 1000;
        exp_gnt_q.push_back(2'b01);
        do_xfer(0, 1'b1, 8'h07, 8'h3C);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            if (PENABLE) begin
                n = 1;
                break;
            end
        end
        chk("reach_access", 32'(n), 32'h1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("reset_mid_xfer", 32'({PSEL, PENABLE, rsp_valid}), 32'h0);
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        wait_n = 0;
        rd_key = 8'h00;
        exp_gnt_q.push_back(2'b01);
        exp_rsp_q.push_back({2'b01, 8'h31, 1'b0});
        req_write = 2'b00;
        req_addr  = {8'h32, 8'h31};
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK); #1;
            if (req_ready != 2'b00) begin
                n = 1;
                break;
            end
        end
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        chk("post_reset_grant_seen", 32'(n), 32'h1);
        drain();

        // stalled slave: timeout abort or indefinite wait
        wait_n = 1000;
        exp_gnt_q.push_back(2'b10);
`ifdef UART_APB_TIMEOUT_EN
        exp_rsp_q.push_back({2'b10, 8'h00, 1'b1});
        do_xfer(1, 1'b0, 8'h05, 8'h00);
        acc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (PENABLE) acc++;
            if (rsp_valid != 2'b00) break;
        end
        chk("timeout_cycles", 32'(acc), 32'd16);
        drain();
`else
        do_xfer(1, 1'b0, 8'h05, 8'h00);
        quiet = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (rsp_valid != 2'b00) quiet++;
        end
        chk("no_timeout_rsp", 32'(quiet), 32'h0);
        chk("still_in_access", 32'({PSEL, PENABLE}), 32'h3);
        exp_rsp_q.push_back({2'b10, 8'h05, 1'b0});
        wait_n = 0;
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
